// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel converter with valid/ready output handshake.
//   Collects N accepted serial bits into a WIDTH-bit word. dir, sampled on the first
//   bit of each word, selects MSB-first (left shift) or LSB-first (right shift).
//   A finished word goes straight to 'out' if it is free or being consumed on the
//   same edge. Otherwise the word is dropped and the sticky 'overrun' flag is set.
// Optional feature macro: PARITY_CHECK_EN -- one even-parity bit follows the data
//   bits (N = WIDTH+1) and parity_err reports it. When undefined, N = WIDTH and
//   parity_err is held at 0.
// Ports:
//   clk            sole clock, rising edge
//   async_reset_n  asynchronous active-low reset
//   sync_reset     synchronous active-high clear (wins over ser_valid/out_ready)
//   ser_in         serial data bit, sampled when ser_valid is high
//   ser_valid      qualifies ser_in
//   dir            1 = MSB-first, 0 = LSB-first
//   out            assembled word
//   out_valid      out holds an unconsumed word
//   out_ready      consumer accepts out when out_valid && out_ready
//   overrun        sticky: a completed word was dropped
//   busy           a word is partially received
//   parity_err     parity failure of the word currently on out
module shift_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             sync_reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] out_d;
  logic             out_valid_d, overrun_d, parity_err_d;
  logic             dir_eff_c;
  logic [WIDTH-1:0] shifted_c;
  logic             complete_c;
  logic [WIDTH-1:0] word_c;
  logic             word_perr_c;
`ifdef PARITY_CHECK_EN
  logic             par_q, par_d;
`endif

  // Direction comes from the port on the first bit and from the latch afterwards.
  assign dir_eff_c = (state_q == IDLE) ? dir : dir_q;
  assign shifted_c = dir_eff_c ? {sreg_q[WIDTH-2:0], ser_in}
                               : {ser_in, sreg_q[WIDTH-1:1]};

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    dir_d        = dir_q;
    out_d        = out;
    out_valid_d  = out_valid;
    overrun_d    = overrun;
    parity_err_d = parity_err;
    complete_c   = 1'b0;
    word_c       = shifted_c;
    word_perr_c  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d        = par_q;
`endif
    if (sync_reset) begin
      state_d      = IDLE;
      cnt_d        = '0;
      sreg_d       = '0;
      dir_d        = 1'b0;
      out_d        = '0;
      out_valid_d  = 1'b0;
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
      par_d        = 1'b0;
`endif
    end else begin
      if (ser_valid) begin
        dir_d = dir_eff_c;
        case (state_q)
          IDLE: begin
            state_d = SHIFT;
            cnt_d   = CW'(1);
            sreg_d  = shifted_c;
`ifdef PARITY_CHECK_EN
            par_d   = ser_in;
`endif
          end
          SHIFT: begin
            if (cnt_q == CW'(NBITS - 1)) begin
              state_d    = IDLE;
              cnt_d      = '0;
              complete_c = 1'b1;
`ifdef PARITY_CHECK_EN
              // Final bit is the parity bit; data is already in the register.
              word_c      = sreg_q;
              word_perr_c = par_q ^ ser_in;
`else
              sreg_d      = shifted_c;
`endif
            end else begin
              cnt_d  = cnt_q + CW'(1);
              sreg_d = shifted_c;
`ifdef PARITY_CHECK_EN
              par_d  = par_q ^ ser_in;
`endif
            end
          end
          default: state_d = IDLE;
        endcase
      end
      if (complete_c) begin
        if (!out_valid || out_ready) begin
          out_d        = word_c;
          out_valid_d  = 1'b1;
          parity_err_d = word_perr_c;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      dir_q      <= 1'b0;
      out        <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      dir_q      <= dir_d;
      out        <= out_d;
      out_valid  <= out_valid_d;
      overrun    <= overrun_d;
      parity_err <= parity_err_d;
`ifdef PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  // busy is the decoded state flop, so it drops as soon as async reset asserts.
  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed and randomized checks of shift_deserializer against
// a queue-based reference model. Honours PARITY_CHECK_EN like the design.
module tb_shift_deserializer;

  localparam int unsigned W = 8;
`ifdef PARITY_CHECK_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif
  localparam bit HAS_PAR = (NB > W);

  logic         clk;
  logic         async_reset_n;
  logic         sync_reset;
  logic         ser_in;
  logic         ser_valid;
  logic         dir;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;
  logic         busy;
  logic         parity_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [W-1:0] m_out;
  logic         m_valid, m_ovr, m_perr;
  logic         m_dir;
  int           m_bits[$];

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .async_reset_n(async_reset_n), .sync_reset(sync_reset),
    .ser_in(ser_in), .ser_valid(ser_valid), .dir(dir), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .busy(busy), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_dir = 1'b0;
    m_bits.delete();
  endtask

  // One rising edge of the reference model, written from the word-level rules.
  task automatic model_edge(input logic sr, input logic sv, input logic si,
                            input logic d, input logic rdy);
    bit hs, done;
    int w, p;
    if (sr) begin
      model_clear();
      return;
    end
    hs = m_valid && rdy;
    done = 0; w = 0; p = 0;
    if (sv) begin
      if (m_bits.size() == 0) m_dir = d;
      m_bits.push_back(int'(si));
      if (m_bits.size() == NB) begin
        done = 1;
        for (int i = 0; i < W; i++)
          w += m_dir ? m_bits[i] * (1 << (W - 1 - i)) : m_bits[i] * (1 << i);
        for (int i = 0; i < NB; i++) p += m_bits[i];
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || hs) begin
        m_out = W'(w); m_valid = 1'b1; m_perr = HAS_PAR ? p[0] : 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs on the falling edge; sample 1 time unit after the rising edge.
  task automatic step(input logic sv, input logic si, input logic d,
                      input logic rdy, input logic sr);
    @(negedge clk);
    ser_valid = sv; ser_in = si; dir = d; out_ready = rdy; sync_reset = sr;
    @(posedge clk);
    model_edge(sr, sv, si, d, rdy);
    #1;
  endtask

  // Sends seq[W-1] first; out_ready is high only on the completing edge when rdy_last.
  task automatic send_seq(input logic [W-1:0] seq, input logic d, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--)
      step(1'b1, seq[i], d, (i == 0 && !HAS_PAR) ? rdy_last : 1'b0, 1'b0);
    if (HAS_PAR) step(1'b1, ^seq, d, rdy_last, 1'b0);
  endtask

  task automatic test_reset();
    async_reset_n = 1'b0; sync_reset = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
    dir = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out !== '0) begin miscompares++; $display("FAIL reset_out: got %h expected 00", out); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    @(negedge clk);
    async_reset_n = 1'b1;
  endtask

  task automatic test_msb_first();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL msb_busy_mid: got %b expected 1", busy); end
    for (int i = W - 2; i >= 0; i--) step(1'b1, (i == W - 2), 1'b1, 1'b0, 1'b0);
    if (HAS_PAR) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++; if (out !== 8'hC0) begin miscompares++; $display("FAIL msb_out: got %h expected c0", out); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL msb_out_valid: got %b expected 1", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL msb_busy: got %b expected 0", busy); end
  endtask

  task automatic test_lsb_first();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'b1100_0000, 1'b0, 1'b0);
    vectors++; if (out !== 8'h03) begin miscompares++; $display("FAIL lsb_out: got %h expected 03", out); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lsb_out_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_overrun();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'b1100_0000, 1'b1, 1'b0);
    send_seq(8'hA5, 1'b1, 1'b0);
    vectors++; if (out !== 8'hC0) begin miscompares++; $display("FAIL ovr_out_held: got %h expected c0", out); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_consumed: got %b expected 0", out_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_complete_handshake();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'b1100_0000, 1'b1, 1'b0);
    send_seq(8'b1100_0000, 1'b0, 1'b1);
    vectors++; if (out !== 8'h03) begin miscompares++; $display("FAIL hs_out: got %h expected 03", out); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hs_out_valid: got %b expected 1", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL hs_overrun: got %b expected 0", overrun); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'h5A, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ser_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL arst_busy_before: got %b expected 1", busy); end
    async_reset_n = 1'b0;
    #1;
    model_clear();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b expected 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out !== '0) begin miscompares++; $display("FAIL arst_out: got %h expected 00", out); end
    @(negedge clk);
    async_reset_n = 1'b1;
    send_seq(8'b1100_0000, 1'b1, 1'b0);
    vectors++; if (out !== 8'hC0) begin miscompares++; $display("FAIL arst_next_word: got %h expected c0", out); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL arst_next_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_dir_ignored();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = W - 1; i >= 0; i--) step(1'b1, (i >= W - 2), (i == W - 1), 1'b0, 1'b0);
    if (HAS_PAR) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (out !== 8'hC0) begin miscompares++; $display("FAIL dir_ignored: got %h expected c0", out); end
  endtask

  task automatic test_sync_reset_mid();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'h81, 1'b1, 1'b0);
    send_seq(8'h81, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL srst_busy: got %b expected 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL srst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL srst_overrun: got %b expected 0", overrun); end
    send_seq(8'b1100_0000, 1'b0, 1'b0);
    vectors++; if (out !== 8'h03) begin miscompares++; $display("FAIL srst_next_word: got %h expected 03", out); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq;
    logic d;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      seq = W'($urandom);
      d = 1'($urandom);
      for (int i = NB - 1; i >= 0; i--) begin
        step(1'b1, (i == 0 && HAS_PAR) ? 1'($urandom) : seq[(HAS_PAR ? i - 1 : i)], d, 1'b1, 1'b0);
        vectors++;
        if (out !== m_out || out_valid !== m_valid || busy !== (m_bits.size() != 0) || overrun !== m_ovr)
          begin miscompares++; $display("FAIL b2b word %0d: got out=%h v=%b busy=%b ovr=%b expected out=%h v=%b busy=%b ovr=%b",
            k, out, out_valid, busy, overrun, m_out, m_valid, (m_bits.size() != 0), m_ovr); end
      end
    end
  endtask

  task automatic test_random();
    logic sv, si, d, rdy, sr;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      sv = ($urandom_range(0, 9) < 7);
      si = 1'($urandom);
      d = 1'($urandom);
      rdy = ($urandom_range(0, 9) < 3);
      sr = ($urandom_range(0, 199) == 0);
      step(sv, si, d, rdy, sr);
      vectors++;
      if (out !== m_out) begin miscompares++; $display("FAIL rand_out cyc %0d: got %h expected %h", n, out, m_out); end
      vectors++;
      if (out_valid !== m_valid) begin miscompares++; $display("FAIL rand_out_valid cyc %0d: got %b expected %b", n, out_valid, m_valid); end
      vectors++;
      if (busy !== (m_bits.size() != 0)) begin miscompares++; $display("FAIL rand_busy cyc %0d: got %b expected %b", n, busy, (m_bits.size() != 0)); end
      vectors++;
      if (overrun !== m_ovr) begin miscompares++; $display("FAIL rand_overrun cyc %0d: got %b expected %b", n, overrun, m_ovr); end
      vectors++;
      if (parity_err !== m_perr) begin miscompares++; $display("FAIL rand_parity_err cyc %0d: got %b expected %b", n, parity_err, m_perr); end
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = W - 1; i >= 0; i--) step(1'b1, (i >= W - 2), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++; if (out !== 8'hC0) begin miscompares++; $display("FAIL par1_out: got %h expected c0", out); end
    vectors++; if (parity_err !== 1'b1) begin miscompares++; $display("FAIL par1_err: got %b expected 1", parity_err); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = W - 1; i >= 0; i--) step(1'b1, (i >= W - 2), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++; if (out !== 8'hC0) begin miscompares++; $display("FAIL par0_out: got %h expected c0", out); end
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL par0_err: got %b expected 0", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_complete_handshake();
    test_async_reset();
    test_dir_ignored();
    test_sync_reset_mid();
    test_back_to_back();
    test_random();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port async_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sync_reset  input  1  synchronous, active-high clear.
REQ-005 SHALL have port ser_in  input  1  serial data bit.
REQ-006 SHALL have port ser_valid  input  1  ser_in sampled on an edge where high.
REQ-007 SHALL have port dir  input  1  1 = MSB-first (left shift), 0 = LSB-first (right shift).
REQ-008 SHALL have port out  output  WIDTH  assembled parallel word.
REQ-009 SHALL have port out_valid  output  1  out holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out when out_valid and out_ready are both high.
REQ-011 SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-012 SHALL have port busy  output  1  a word is partially received.
REQ-013 SHALL have port parity_err  output  1  parity failure of the word currently on out.

Function
REQ-014 SHALL use a two-state FSM: IDLE (bit count 0) and SHIFT (bit count 1..N-1), where N = WIDTH data bits plus, when enabled, 1 parity bit.
REQ-015 SHALL sample dir on the first accepted bit of each word; changes to dir during SHIFT SHALL be ignored.
REQ-016 SHALL, MSB-first, shift the register left with ser_in into bit 0; LSB-first, shift right with ser_in into bit WIDTH-1.
REQ-017 SHALL ignore ser_in on edges where ser_valid is low; the bit count and register SHALL hold.
REQ-018 SHALL drive busy high exactly while in SHIFT.
REQ-019 SHALL, on the edge accepting bit N, return to IDLE and complete the word.
REQ-020 SHALL, on completion with out_valid low, load out and set out_valid high on that same edge (zero extra latency).
REQ-021 SHALL hold out and out_valid stable until the handshake; the handshake SHALL clear out_valid on that edge.
REQ-022 SHALL, on completion coinciding with a handshake, load the new word and keep out_valid high.
REQ-023 SHALL, on completion while out_valid is high and out_ready is low, drop the new word, keep out unchanged, and set overrun.
REQ-024 SHALL keep overrun set until reset or sync_reset.
REQ-025 SHALL allow back-to-back words: the first bit of the next word is accepted on the edge after completion.

Reset
REQ-026 SHALL, on async_reset_n low, immediately clear out, out_valid, overrun, busy, parity_err, bit count and shift register; FSM to IDLE.
REQ-027 SHALL apply sync_reset identically on the next edge, with priority over ser_valid and out_ready.
REQ-028 SHALL discard any partial word when reset occurs mid-word; the next accepted bit starts a new word.

Configuration
REQ-029 SHALL, when PARITY_CHECK_EN is defined, expect one even-parity bit after the WIDTH data bits (N = WIDTH+1); parity_err is loaded with out and is high when the XOR of data and parity bits is 1.
REQ-030 SHALL, when PARITY_CHECK_EN is undefined, complete after WIDTH bits and tie parity_err to 0.

Verification (WIDTH=8, parity disabled unless stated)
REQ-031 SHALL verify: dir=1, bits 1,1,0,0,0,0,0,0 on consecutive edges -> out=0xC0, out_valid high after 8th edge, busy low.
REQ-032 SHALL verify: dir=0, same bit sequence -> out=0x03.
REQ-033 SHALL verify: word 0xC0 held with out_ready=0, second word completes -> out stays 0xC0, overrun=1; out_ready=1 -> out_valid=0, overrun stays 1.
REQ-034 SHALL verify: out_ready=1 on the completion edge of a second word 0x03 -> out=0x03, out_valid stays 1, overrun=0.
REQ-035 SHALL verify: async_reset_n pulsed low after 4 bits -> busy=0 without waiting for a clock edge; next 8 bits 0xC0 MSB-first -> out=0xC0.
REQ-036 SHALL verify: PARITY_CHECK_EN, 0xC0 then parity 1 -> parity_err=1; 0xC0 then parity 0 -> parity_err=0.
